// File: rtl/shiftreg_burst_sched_pkg.sv
// rtl/shiftreg_burst_sched_pkg.sv - shared state encoding and counter width helper
package shiftreg_burst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // A counter must hold 0..max_val; a zero-range counter still needs one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/shiftreg_burst_sched_rr_arb2.sv
// rtl/shiftreg_burst_sched_rr_arb2.sv - two-input round-robin arbiter
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic       winner,
  output logic       grant_valid
);

  assign grant_valid = |valid;
  assign winner      = valid[pointer] ? pointer : ~pointer;

endmodule

// File: rtl/shiftreg_burst_sched.sv
// rtl/shiftreg_burst_sched.sv - round-robin burst scheduler feeding one tapped shift register
module shiftreg_burst_sched
  import shiftreg_burst_sched_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYC    = 4,
  parameter int FILL_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              flush,
  output logic              sr_aclr,
  output logic              sr_clken,
  output logic [DATA_W-1:0] sr_shiftin,
  output logic              taps_valid,
  output logic              grant_id,
  output logic              busy
);

  localparam int BEAT_W = cnt_w(BURST_LEN);
  localparam int GAP_W  = cnt_w(GAP_CYC);
  localparam int FILL_W = cnt_w(FILL_DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(FILL_DEPTH);

  state_t              state;
  logic                rr_ptr;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [FILL_W-1:0]   fill_next;
  logic                arb_winner;
  logic                arb_valid;
  logic                in_burst;
  logic                accept;
  logic [DATA_W-1:0]   beat_data;

  rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .pointer     (rr_ptr),
    .winner      (arb_winner),
    .grant_valid (arb_valid)
  );

  // A sampled flush blocks acceptance so no beat slips past the clear.
  assign in_burst   = (state == BURST) && !flush;
  assign req0_ready = in_burst && !grant_id;
  assign req1_ready = in_burst && grant_id;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign beat_data  = grant_id ? req1_data : req0_data;
  assign busy       = (state != IDLE);
  assign fill_next  = (fill_cnt == FILL_MAX) ? FILL_MAX : fill_cnt + FILL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      grant_id   <= 1'b0;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      fill_cnt   <= '0;
      taps_valid <= 1'b0;
      sr_aclr    <= 1'b0;
      sr_clken   <= 1'b0;
      sr_shiftin <= '0;
    end else begin
      sr_aclr  <= 1'b0;
      sr_clken <= accept;
      if (accept) sr_shiftin <= beat_data;
      if (flush) begin
        // A shift issued in this cycle is discarded together with the fill count.
        state      <= FLUSH;
        sr_aclr    <= 1'b1;
        fill_cnt   <= '0;
        taps_valid <= 1'b0;
        beat_cnt   <= '0;
        gap_cnt    <= '0;
      end else begin
        if (sr_clken) begin
          fill_cnt   <= fill_next;
          taps_valid <= (fill_next == FILL_MAX);
        end
        case (state)
          IDLE: begin
            if (arb_valid) begin
              grant_id <= arb_winner;
              rr_ptr   <= ~arb_winner;
              beat_cnt <= '0;
              state    <= BURST;
            end
          end
          BURST: begin
            if (accept) begin
              if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                gap_cnt  <= '0;
                state    <= (GAP_CYC == 0) ? IDLE : GAP;
              end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) state <= IDLE;
            else gap_cnt <= gap_cnt + GAP_W'(1);
          end
          FLUSH:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
